// File: rtl/bram_port_arbiter.sv
// Round-robin owner of the single BRAM port shared by NUM_REQ requesters, with bounded
// bursts and a tag pipeline routing read data back to its issuer. Optional counters: BRAM_ARB_STATS_EN.
module bram_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int AW        = 12,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wrdata,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      rvalid,
  output logic [31:0]             rdata,
  output logic [31:0]             BRAM_ADDR,
  output logic [31:0]             BRAM_WRDATA,
  output logic [3:0]              BRAM_WE,
  input  logic [31:0]             BRAM_RDDATA
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [31:0]             stat_beats,
  output logic [31:0]             stat_wait
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [IDW-1:0]       rr_ptr_r, rr_ptr_s;
  logic [IDW-1:0]       owner_r, owner_s;
  logic [7:0]           beat_cnt_r, beat_cnt_s;
  logic [NUM_REQ-1:0]   grant_r, grant_s;
  logic [NUM_REQ-1:0]   tag_pipe_r [RD_LAT];
  logic [IDW-1:0]       pick_s;
  logic [IDW-1:0]       next_ptr_s;
  logic                 beat_s;
  logic                 last_s;

  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    logic           found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign pick_s     = rr_pick(req, rr_ptr_r);
  assign next_ptr_s = (owner_r == IDW'(NUM_REQ - 1)) ? '0 : owner_r + IDW'(1);
  assign beat_s     = (state_r == S_BUSY) && req[owner_r] && grant_r[owner_r];
  assign last_s     = (beat_cnt_r == 8'(MAX_BURST - 1));

  // Arbitration state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r    <= S_IDLE;
      rr_ptr_r   <= '0;
      owner_r    <= '0;
      beat_cnt_r <= 8'd0;
      grant_r    <= '0;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      owner_r    <= owner_s;
      beat_cnt_r <= beat_cnt_s;
      grant_r    <= grant_s;
    end
  end

  // Next owner, burst count and grant; a release always passes through one idle bubble.
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    owner_s    = owner_r;
    beat_cnt_s = beat_cnt_r;
    grant_s    = grant_r;
    case (state_r)
      S_IDLE: begin
        if (|req) begin
          state_s    = S_BUSY;
          owner_s    = pick_s;
          grant_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
          beat_cnt_s = 8'd0;
        end else begin
          grant_s    = '0;
        end
      end
      S_BUSY: begin
        if (!req[owner_r] || (beat_s && last_s)) begin
          state_s  = S_IDLE;
          grant_s  = '0;
          rr_ptr_s = next_ptr_s;
        end else if (beat_s) begin
          beat_cnt_s = beat_cnt_r + 8'd1;
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        grant_s = '0;
      end
    endcase
  end

  // BRAM port is driven from the owner's slice only in a beat cycle.
  always_comb begin
    BRAM_ADDR   = 32'h0000_0000;
    BRAM_WRDATA = 32'h0000_0000;
    BRAM_WE     = 4'h0;
    if (beat_s) begin
      BRAM_ADDR   = 32'({req_addr[owner_r*AW +: AW], 2'b00});
      BRAM_WRDATA = req_wrdata[owner_r*32 +: 32];
      BRAM_WE     = req_we[owner_r] ? 4'hF : 4'h0;
    end else begin
      BRAM_ADDR   = 32'h0000_0000;
      BRAM_WRDATA = 32'h0000_0000;
      BRAM_WE     = 4'h0;
    end
  end

  // One-hot issuer tags follow each read through the BRAM latency, independent of the current grant.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tag_pipe_r[s] <= '0;
      end
    end else begin
      tag_pipe_r[0] <= (beat_s && !req_we[owner_r]) ? grant_r : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        tag_pipe_r[s] <= tag_pipe_r[s-1];
      end
    end
  end

  assign grant  = grant_r;
  assign rvalid = tag_pipe_r[RD_LAT-1];
  assign rdata  = BRAM_RDDATA;

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] stat_beats_r;
  logic [31:0] stat_wait_r;
  logic        wait_s;

  assign wait_s = |(req & ~((state_r == S_BUSY) ? grant_r : {NUM_REQ{1'b0}}));

  // Saturating beat and contention counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_beats_r <= 32'h0000_0000;
      stat_wait_r  <= 32'h0000_0000;
    end else begin
      if (beat_s && (stat_beats_r != 32'hFFFF_FFFF)) begin
        stat_beats_r <= stat_beats_r + 32'd1;
      end
      if (wait_s && (stat_wait_r != 32'hFFFF_FFFF)) begin
        stat_wait_r <= stat_wait_r + 32'd1;
      end
    end
  end

  assign stat_beats = stat_beats_r;
  assign stat_wait  = stat_wait_r;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level reference model with its own memory image.
module tb_bram_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int AW        = 12;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;

  logic                  aclk = 1'b0;
  logic                  areset;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wrdata;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    rvalid;
  logic [31:0]           rdata;
  logic [31:0]           BRAM_ADDR;
  logic [31:0]           BRAM_WRDATA;
  logic [3:0]            BRAM_WE;
  logic [31:0]           BRAM_RDDATA;
`ifdef BRAM_ARB_STATS_EN
  logic [31:0]           stat_beats;
  logic [31:0]           stat_wait;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  bram_port_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .aclk(aclk), .areset(areset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wrdata(req_wrdata), .grant(grant), .rvalid(rvalid), .rdata(rdata),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_RDDATA(BRAM_RDDATA)
`ifdef BRAM_ARB_STATS_EN
    , .stat_beats(stat_beats), .stat_wait(stat_wait)
`endif
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'(a) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  // Behavioural BRAM: word-addressed, data valid RD_LAT cycles after the address cycle.
  bit [31:0] mem [0:4095];
  bit        init_done;
  bit [31:0] rd_dly [RD_LAT];

  always @(posedge aclk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (BRAM_WE == 4'hF) begin
      mem[BRAM_ADDR[13:2]] <= BRAM_WRDATA;
    end
    rd_dly[0] <= mem[BRAM_ADDR[13:2]];
    for (int s = 1; s < RD_LAT; s++) rd_dly[s] <= rd_dly[s-1];
  end

  assign BRAM_RDDATA = rd_dly[RD_LAT-1];

  // Reference model: owner index (-1 = nobody), beats taken, next search start, expected returns by cycle.
  logic [31:0]        ref_mem [0:4095];
  int                 m_owner;
  int                 m_cnt;
  int                 m_ptr;
  int                 cyc;
  logic [NUM_REQ-1:0] exp_rv [8];
  logic [31:0]        exp_rd [8];
  logic [NUM_REQ-1:0] last_acc;
  int                 left [NUM_REQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    for (int s = 0; s < 8; s++) begin
      exp_rv[s] = '0;
      exp_rd[s] = 32'h0;
    end
  endtask

  task automatic model_check();
    logic [NUM_REQ-1:0] g_exp;
    logic [31:0]        a_exp;
    logic [31:0]        d_exp;
    logic [3:0]         we_exp;
    bit                 beat;
    bit                 found;
    int                 a;
    int                 slot;
    int                 cand;
    beat   = 1'b0;
    a      = 0;
    g_exp  = '0;
    if (m_owner >= 0) begin
      g_exp = NUM_REQ'(1) << m_owner;
      beat  = (req[m_owner] == 1'b1);
    end
    if (beat) a = int'(req_addr[m_owner*AW +: AW]);
    a_exp  = beat ? 32'(a * 4) : 32'h0;
    d_exp  = beat ? req_wrdata[m_owner*32 +: 32] : 32'h0;
    we_exp = (beat && req_we[m_owner]) ? 4'hF : 4'h0;
    slot   = cyc % 8;
    chk("grant", 32'(grant), 32'(g_exp));
    chk("rvalid", 32'(rvalid), 32'(exp_rv[slot]));
    if (exp_rv[slot] != '0) chk("rdata", rdata, exp_rd[slot]);
    chk("bram_we", 32'(BRAM_WE), 32'(we_exp));
    chk("bram_addr", BRAM_ADDR, a_exp);
    chk("bram_wrdata", BRAM_WRDATA, d_exp);
    exp_rv[slot] = '0;
    if (beat) begin
      if (req_we[m_owner]) begin
        ref_mem[a] = d_exp;
      end else begin
        exp_rv[(cyc + RD_LAT) % 8] = g_exp;
        exp_rd[(cyc + RD_LAT) % 8] = ref_mem[a];
      end
    end
    if (areset) begin
      model_clear();
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (m_ptr + k) % NUM_REQ;
        if (!found && req[cand]) begin
          m_owner = cand;
          found   = 1'b1;
        end
      end
      m_cnt = 0;
    end else if (!beat) begin
      m_ptr   = (m_owner + 1) % NUM_REQ;
      m_owner = -1;
    end else begin
      m_cnt++;
      if (m_cnt == MAX_BURST) begin
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end
    end
    cyc++;
  endtask

  task automatic to_neg();
    @(negedge aclk);
    last_acc = grant & req;
    model_check();
  endtask

  task automatic to_pos();
    @(posedge aclk);
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req    = '0;
    tick();
    areset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic on, input logic we, input int addr,
                         input logic [31:0] data);
    req[i]                 = on;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = AW'(addr);
    req_wrdata[i*32 +: 32] = data;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (left[i] > 0) begin
        if (last_acc[i]) begin
          left[i] = ($urandom_range(0, 7) == 0) ? 0 : left[i] - 1;
          set_req(i, left[i] > 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  32'($urandom));
        end
      end else if ($urandom_range(0, 3) == 0) begin
        left[i] = int'($urandom_range(1, 7));
        set_req(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 32'($urandom));
      end else begin
        req[i] = 1'b0;
      end
    end
    areset = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    areset     = 1'b1;
    req        = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wrdata = '0;
    last_acc   = '0;
    cyc        = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < NUM_REQ; i++) left[i] = 0;
    model_clear();
    @(posedge aclk);
    #1;

    // Reset state, then a single read from requester 0.
    to_neg();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    to_pos();
    areset = 1'b0;
    set_req(0, 1'b1, 1'b0, 5, 32'h0);
    to_neg(); chk("a_idle_grant", 32'(grant), 32'h0); to_pos();
    to_neg(); chk("a_grant0", 32'(grant), 32'h1); chk("a_addr", BRAM_ADDR, 32'h14); to_pos();
    req[0] = 1'b0;
    tick();
    to_neg(); chk("a_rvalid0", 32'(rvalid), 32'h1); chk("a_rdata", rdata, init_word(5)); to_pos();
    repeat (2) tick();

    // Simultaneous req1/req3 from rr_ptr=0, then wrap back to requester 0.
    do_reset();
    set_req(1, 1'b1, 1'b0, 7, 32'h0);
    set_req(3, 1'b1, 1'b0, 9, 32'h0);
    tick();
    to_neg(); chk("b_first_req1", 32'(grant), 32'h2); to_pos();
    tick();
    req[1] = 1'b0;
    to_neg(); chk("b_release_hold", 32'(grant), 32'h2); to_pos();
    to_neg(); chk("b_bubble", 32'(grant), 32'h0); to_pos();
    to_neg(); chk("b_grant3", 32'(grant), 32'h8); to_pos();
    req[3] = 1'b0;
    set_req(0, 1'b1, 1'b0, 1, 32'h0);
    set_req(2, 1'b1, 1'b0, 2, 32'h0);
    tick();
    to_neg(); chk("b_bubble2", 32'(grant), 32'h0); to_pos();
    to_neg(); chk("b_wrap_grant0", 32'(grant), 32'h1); to_pos();
    req = '0;
    repeat (4) tick();

    // Continuous writes from requester 0: four beats, one bubble, repeat.
    set_req(0, 1'b1, 1'b1, 12'h100, 32'hA000_0000);
    for (int k = 0; k < 11; k++) begin
      to_neg();
      chk("c_grant", 32'(grant), (k % 5 == 0) ? 32'h0 : 32'h1);
      chk("c_we", 32'(BRAM_WE), (k % 5 == 0) ? 32'h0 : 32'hF);
      to_pos();
      if (last_acc[0]) begin
        req_addr[AW-1:0]  = req_addr[AW-1:0] + AW'(1);
        req_wrdata[31:0]  = req_wrdata[31:0] + 32'd1;
      end
    end
    req = '0;
    repeat (3) tick();

    // Three reads from requester 0 crossing into a write from requester 2.
    set_req(0, 1'b1, 1'b0, 10, 32'h0);
    tick();
    tick();
    req_addr[AW-1:0] = AW'(11);
    tick();
    req_addr[AW-1:0] = AW'(12);
    set_req(2, 1'b1, 1'b1, 12'h200, 32'hCAFE_0002);
    to_neg(); chk("d_rv_1", 32'(rvalid), 32'h1); chk("d_rd_1", rdata, ref_mem[10]); to_pos();
    req[0] = 1'b0;
    to_neg(); chk("d_rv_2", 32'(rvalid), 32'h1); chk("d_rd_2", rdata, ref_mem[11]); to_pos();
    to_neg();
    chk("d_rv_3", 32'(rvalid), 32'h1);
    chk("d_rd_3", rdata, ref_mem[12]);
    chk("d_bubble", 32'(grant), 32'h0);
    to_pos();
    to_neg();
    chk("d_grant2", 32'(grant), 32'h4);
    chk("d_we", 32'(BRAM_WE), 32'hF);
    chk("d_addr", BRAM_ADDR, 32'h800);
    chk("d_wrdata", BRAM_WRDATA, 32'hCAFE_0002);
    to_pos();
    req[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_neg(); chk("d_no_rvalid", 32'(rvalid), 32'h0); to_pos();
    end

    // Reset in the middle of a read stream.
    set_req(0, 1'b1, 1'b0, 20, 32'h0);
    tick();
    tick();
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    set_req(1, 1'b1, 1'b0, 21, 32'h0);
    to_neg(); chk("e_grant_after_rst", 32'(grant), 32'h0); chk("e_rv_flushed", 32'(rvalid), 32'h0); to_pos();
    to_neg(); chk("e_ptr0_grant", 32'(grant), 32'h1); chk("e_rv_flushed2", 32'(rvalid), 32'h0); to_pos();
    req = '0;
    repeat (4) tick();

`ifdef BRAM_ARB_STATS_EN
    // Two continuous writers for twenty cycles.
    do_reset();
    set_req(0, 1'b1, 1'b1, 30, 32'h1111_0000);
    set_req(1, 1'b1, 1'b1, 31, 32'h2222_0000);
    repeat (20) tick();
    to_neg();
    chk("stat_beats", stat_beats, 32'd16);
    chk("stat_wait_ge15", {31'h0, stat_wait >= 32'd15}, 32'h1);
    to_pos();
    req = '0;
    repeat (3) tick();
`endif

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      tick();
    end
    areset = 1'b0;
    req    = '0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single external BRAM port (BRAM_ADDR/WRDATA/WE/RDDATA) between NUM_REQ requesters, such as the PE controller's load engine, result writeback and host-side debug reader.
- Round-robin arbitration with bounded burst ownership.
- Read data is routed back to the issuing requester through a fixed-latency tag pipeline.
- Sits between the PE controller(s) and the BRAM controller in the same clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AW, 12, requester word-address width; BRAM_ADDR is the byte address {addr, 2'b00}, zero-extended to 32 bits.
- RD_LAT, 2, BRAM read latency in cycles, counted from the beat cycle to the cycle BRAM_RDDATA is valid (1..4).
- MAX_BURST, 64, maximum consecutive beats per grant (1..256).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester access request; held high while the requester has beats to issue.
- req_we  in  NUM_REQ  per-requester write select; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*AW  packed word addresses; requester i occupies slice [i*AW +: AW].
- req_wrdata  in  NUM_REQ*32  packed write data.
- grant  out  NUM_REQ  one-hot (or zero) ownership indication, registered.
- rvalid  out  NUM_REQ  one-cycle read-return strobe to the issuing requester.
- rdata  out  32  read data, broadcast to all requesters; qualify with rvalid.
- BRAM_ADDR  out  32  byte address to the BRAM.
- BRAM_WRDATA  out  32  write data to the BRAM.
- BRAM_WE  out  4  byte write enables.
- BRAM_RDDATA  in  32  read data from the BRAM.

Behaviour:
- States:
  - S_IDLE: no owner.
  - S_BUSY: owner register valid.
- Reset values (areset=1): state=S_IDLE, rr_ptr=0, owner=0, beat_cnt=0, grant=0, rvalid=0, tag pipeline cleared.
- S_IDLE:
  - If any req is high, select the first requester at or after rr_ptr, searching cyclically.
  - Next cycle: state=S_BUSY, grant=onehot(owner), beat_cnt=0.
  - Arbitration latency is one cycle.
- S_BUSY beat:
  - A beat occurs when req[owner]=1 in a cycle with grant[owner]=1.
  - BRAM_ADDR, BRAM_WRDATA and BRAM_WE are combinational from the owner's slice in that same cycle.
  - BRAM_WE=4'hF when req_we[owner]=1, else 4'h0.
- No-beat cycles: BRAM_ADDR=0, BRAM_WRDATA=0, BRAM_WE=0.
- Beat accounting: each beat increments beat_cnt (8-bit wide is sufficient).
- Release: in S_BUSY, if req[owner]=0, or a beat occurs with beat_cnt==MAX_BURST-1:
  - next state=S_IDLE, grant=0, rr_ptr=(owner+1) mod NUM_REQ.
  - Each release costs one idle bubble cycle.
  - If the released owner still requests, it re-arbitrates normally; others ahead of it in rr order win.
- Requester contract:
  - A requester samples grant and may change addr/wrdata/we only after a cycle in which it saw its beat accepted (grant high while req high).
  - Dropping req while granted ends ownership with no beat issued.
- Read return:
  - Each read beat pushes (valid=1, id=owner) into an RD_LAT-deep shift pipeline.
  - At the pipeline output: rvalid[id]=1 for exactly one cycle, rdata=BRAM_RDDATA in that same cycle.
  - Write beats push valid=0.
  - Back-to-back reads yield back-to-back rvalid, in issue order.
- Reads crossing an ownership change:
  - In-flight reads complete to the original issuer even after release; tags are not tied to the current grant.
- Boundaries:
  - MAX_BURST=1 gives strict round robin at 50% port throughput.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - With a single active requester, it regains the grant after each bubble.
- Reset mid-operation: grant drops the next cycle, the tag pipeline is flushed, and pending reads never produce rvalid.
- Invariants: grant is never multi-hot; BRAM_WE≠0 only when exactly one grant bit is set and that requester's req is high.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- When defined, adds two 32-bit outputs, cleared on areset and saturating at 32'hFFFFFFFF:
  - stat_beats: total beats issued.
  - stat_wait: cycles in which at least one non-owner requester has req=1.
- When undefined, the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then req=4'b0001 read, addr=5, RD_LAT=2:
  - grant[0] at cycle 1, BRAM_ADDR=0x14 at cycle 1.
  - rvalid[0] at cycle 3 with rdata = the BRAM word at 5.
- req=4'b1010 raised together at rr_ptr=0:
  - req1 is granted first.
  - After req1 drops: one idle cycle, then grant[3]; rr_ptr=2 after that.
- MAX_BURST=4, req0 writes continuously:
  - Exactly 4 beats with WE=4'hF, then one bubble with grant=0.
  - req0 is regranted and the pattern repeats.
- req0 issues 3 reads and releases on the last beat, req2 issues a write immediately after:
  - rvalid[0] fires 3 times on consecutive cycles, never rvalid[2].
  - The write appears on BRAM with the correct address.
- areset pulsed during req0's read stream:
  - The cycle after reset is deasserted: grant=0, no rvalid.
  - The next request is arbitrated from rr_ptr=0.
- With BRAM_ARB_STATS_EN, req0 and req1 both continuously active for 20 cycles at MAX_BURST=4:
  - stat_beats=16, stat_wait ≥15.
